cpu_ctrl_mc: RTL and testbench
==============================

// Module: cpu_ctrl_mc
// PURPOSE
//  Multi-cycle datapath controller, successor to the Lab 7 controller. Decodes opcode/op from the IR
//  and sequences datapath/memory strobes. Adds parametrised RAM latency, an explicit fetch-wait state,
//  run/resume from HALT, an illegal-instruction pulse and a retired-instruction counter.
// PARAMETERS
//  MEM_LAT  1   RAM read latency in cycles (>=1); FTCH and MRD each last exactly MEM_LAT cycles
//  CNT_W    16  width of retired-instruction counter (wraps modulo 2^CNT_W)
// PORTS
//  clk          in   1      clock; all state changes on posedge
//  reset        in   1      synchronous, active-high
//  opcode       in   3      IR[15:13]
//  op           in   2      IR[12:11]
//  run          in   1      leave HALT (sampled only in HALT)
//  loadir,msel,mwrite out 1 IR load / mem addr sel (1=datapath C) / mem write
//  nsel         out  2      00=Rn 01=Rd 10=Rm
//  vsel         out  2      00=mdata 01=sximm8 10=PC 11=C
//  write,asel,bsel,loada,loadb,loadc,loads out 1 regfile/datapath strobes
//  tsel,incp,execb out 1    PC: tsel 1=branch target 0=RA; incp=PC+1; execb=load PC
//  halted       out  1      high while in HALT
//  illegal      out  1      one-cycle pulse in LDPC when decode is undefined
//  state        out  5      current state (registered)
//  retired      out  CNT_W  instructions completed since reset
// BEHAVIOUR
//  reset, synchronous, active-high; clock clk. Reset: state<=RST, retired<=0; every output is 0 in RST.
//  Outputs are combinational from state (+opcode/op); any output not listed below is 0.
//  States: RST0 FTCH1 LDIR2 LDPC3 RDRN4 RDRM5 WRRN6 CALC7 STAT8 WMEM9 WRRD10 RDRD11 EXBR12 HALT13
//          BXRD14 BXPC15 MRD16. Codes 17-31 unreachable -> RST.
//  RST->FTCH. FTCH: msel=0, waits MEM_LAT cycles (down-counter loaded on entry) ->LDIR.
//  LDIR: loadir=1 ->LDPC. LDPC: incp=1, decode {opcode,op}:
//    110_10 MOVi  ->WRRN(nsel=00,vsel=01,write)->FTCH
//    110_00 MOV, 101_11 MVN ->RDRM(nsel=10,loadb)->CALC
//    101_00 ADD, 101_10 AND, 101_01 CMP, 011_xx LDR, 100_xx STR ->RDRN(nsel=00,loada)
//        RDRN: opcode 101 ->RDRM; else ->CALC
//    001_xx B, 010_11 BL ->EXBR(execb,tsel=1; BL adds nsel=00,vsel=10,write)->FTCH
//    010_00 BX ->BXRD(nsel=01,loada)->BXPC(execb,tsel=0)->FTCH
//    111_xx HALT ->HALT;  000_00 NOP ->FTCH
//    any other code: illegal=1, treated as NOP ->FTCH
//  CALC: loadc=1 except CMP (0); bsel=1 for LDR/STR; asel=1 for opcode 110.
//    CMP->STAT(loads)->FTCH; LDR->MRD; STR->RDRD; else->WRRD.
//  MRD: msel=1, mwrite=0, MEM_LAT cycles ->WRRD. WRRD: nsel=01,write=1; LDR: vsel=00,msel=1; else vsel=11.
//  RDRD: nsel=01,loadb ->WMEM(msel=1,mwrite=1, one cycle)->FTCH.
//  HALT: halted=1; run=1 ->FTCH (PC already points past HALT); run ignored elsewhere.
//  retired increments by 1 on every transition into FTCH except from RST; wraps; HALT->FTCH counts.
//  opcode/op must stay stable from LDPC to FTCH (IR loads only in LDIR).
//  reset has priority over all transitions, including mid-wait in FTCH/MRD and in HALT.
// TESTING
//  MEM_LAT=1, MOVi: reset, release -> state RST,FTCH,LDIR,LDPC,WRRN,FTCH; WRRN: write=1 vsel=01; retired=1
//  MEM_LAT=3, LDR: FTCH 3 cycles, MRD 3 cycles msel=1 mwrite=0, WRRD vsel=00 nsel=01 write=1
//  STR: RDRN,CALC(bsel=1,loadc=1),RDRD(nsel=01,loadb),WMEM(msel=mwrite=1) 1 cycle, then FTCH
//  BL 010_11: EXBR has execb=1,tsel=1,write=1,vsel=10,nsel=00; BX: BXRD nsel=01 loada, BXPC execb tsel=0
//  HALT, run=0 10 cycles -> stays HALT halted=1; run=1 -> FTCH next; CMP: STAT loads=1, loadc=0 in CALC
//  opcode 000_01 -> illegal pulse 1 cycle in LDPC, ->FTCH; reset mid-MRD -> RST next edge, retired=0;
//  CNT_W=4, 17 NOPs -> retired=1

Source files
------------

// File: rtl/cpu_ctrl_mc_if.sv
// Controller <-> datapath bundle: IR fields and run in, datapath/memory strobes and status out.
// master is the controller side; slave is the datapath (or bench) side.
interface cpu_ctrl_mc_if #(
    parameter int unsigned CNT_W = 16
);
    logic [2:0]       opcode;
    logic [1:0]       op;
    logic             run;
    logic             loadir;
    logic             msel;
    logic             mwrite;
    logic [1:0]       nsel;
    logic [1:0]       vsel;
    logic             write;
    logic             asel;
    logic             bsel;
    logic             loada;
    logic             loadb;
    logic             loadc;
    logic             loads;
    logic             tsel;
    logic             incp;
    logic             execb;
    logic             halted;
    logic             illegal;
    logic [4:0]       state;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, op, run,
        output loadir, msel, mwrite, nsel, vsel, write, asel, bsel, loada, loadb, loadc, loads,
               tsel, incp, execb, halted, illegal, state, retired
    );

    modport slave (
        output opcode, op, run,
        input  loadir, msel, mwrite, nsel, vsel, write, asel, bsel, loada, loadb, loadc, loads,
               tsel, incp, execb, halted, illegal, state, retired
    );
endinterface

// File: rtl/cpu_ctrl_mc.sv
// Multi-cycle datapath controller: fetch/decode/execute sequencing with parametrised RAM
// latency, HALT/run, illegal-instruction pulse and a retired-instruction counter.
module cpu_ctrl_mc #(
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned CNT_W   = 16
) (
    input logic           clk,
    input logic           reset,
    cpu_ctrl_mc_if.master bus
);
    localparam int unsigned WaitW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [4:0] {
        StRst  = 5'd0,  StFtch = 5'd1,  StLdir = 5'd2,  StLdpc = 5'd3,
        StRdrn = 5'd4,  StRdrm = 5'd5,  StWrrn = 5'd6,  StCalc = 5'd7,
        StStat = 5'd8,  StWmem = 5'd9,  StWrrd = 5'd10, StRdrd = 5'd11,
        StExbr = 5'd12, StHalt = 5'd13, StBxrd = 5'd14, StBxpc = 5'd15,
        StMrd  = 5'd16
    } state_e;

    state_e               state_q, state_d;
    logic [WaitW-1:0]     wait_q, wait_d;
    logic [CNT_W-1:0]     retired_q, retired_d;
    logic [4:0]           ir;
    logic                 is_cmp;

    assign ir     = {bus.opcode, bus.op};
    assign is_cmp = (ir == 5'b101_01);

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        retired_d   = retired_q;
        bus.loadir  = 1'b0;
        bus.msel    = 1'b0;
        bus.mwrite  = 1'b0;
        bus.nsel    = 2'b00;
        bus.vsel    = 2'b00;
        bus.write   = 1'b0;
        bus.asel    = 1'b0;
        bus.bsel    = 1'b0;
        bus.loada   = 1'b0;
        bus.loadb   = 1'b0;
        bus.loadc   = 1'b0;
        bus.loads   = 1'b0;
        bus.tsel    = 1'b0;
        bus.incp    = 1'b0;
        bus.execb   = 1'b0;
        bus.halted  = 1'b0;
        bus.illegal = 1'b0;

        case (state_q)
            StRst:  state_d = StFtch;
            StFtch: begin
                if (wait_q == '0) state_d = StLdir;
                else              wait_d  = wait_q - WaitW'(1);
            end
            StLdir: begin
                bus.loadir = 1'b1;
                state_d    = StLdpc;
            end
            StLdpc: begin
                bus.incp = 1'b1;
                casez (ir)
                    5'b110_10:                       state_d = StWrrn;
                    5'b110_00, 5'b101_11:            state_d = StRdrm;
                    5'b101_00, 5'b101_10, 5'b101_01,
                    5'b011_??, 5'b100_??:            state_d = StRdrn;
                    5'b001_??, 5'b010_11:            state_d = StExbr;
                    5'b010_00:                       state_d = StBxrd;
                    5'b111_??:                       state_d = StHalt;
                    5'b000_00:                       state_d = StFtch;
                    default: begin
                        bus.illegal = 1'b1;
                        state_d     = StFtch;
                    end
                endcase
            end
            StWrrn: begin
                bus.vsel  = 2'b01;
                bus.write = 1'b1;
                state_d   = StFtch;
            end
            StRdrn: begin
                bus.loada = 1'b1;
                state_d   = (bus.opcode == 3'b101) ? StRdrm : StCalc;
            end
            StRdrm: begin
                bus.nsel  = 2'b10;
                bus.loadb = 1'b1;
                state_d   = StCalc;
            end
            StCalc: begin
                bus.loadc = !is_cmp;
                bus.bsel  = (bus.opcode == 3'b011) || (bus.opcode == 3'b100);
                bus.asel  = (bus.opcode == 3'b110);
                if (is_cmp)                    state_d = StStat;
                else if (bus.opcode == 3'b011) state_d = StMrd;
                else if (bus.opcode == 3'b100) state_d = StRdrd;
                else                           state_d = StWrrd;
            end
            StStat: begin
                bus.loads = 1'b1;
                state_d   = StFtch;
            end
            StMrd: begin
                bus.msel = 1'b1;
                if (wait_q == '0) state_d = StWrrd;
                else              wait_d  = wait_q - WaitW'(1);
            end
            StWrrd: begin
                bus.nsel  = 2'b01;
                bus.write = 1'b1;
                if (bus.opcode == 3'b011) bus.msel = 1'b1;
                else                      bus.vsel = 2'b11;
                state_d = StFtch;
            end
            StRdrd: begin
                bus.nsel  = 2'b01;
                bus.loadb = 1'b1;
                state_d   = StWmem;
            end
            StWmem: begin
                bus.msel   = 1'b1;
                bus.mwrite = 1'b1;
                state_d    = StFtch;
            end
            StExbr: begin
                bus.execb = 1'b1;
                bus.tsel  = 1'b1;
                if (ir == 5'b010_11) begin
                    bus.vsel  = 2'b10;
                    bus.write = 1'b1;
                end
                state_d = StFtch;
            end
            StBxrd: begin
                bus.nsel  = 2'b01;
                bus.loada = 1'b1;
                state_d   = StBxpc;
            end
            StBxpc: begin
                bus.execb = 1'b1;
                state_d   = StFtch;
            end
            StHalt: begin
                bus.halted = 1'b1;
                if (bus.run) state_d = StFtch;
            end
            default: state_d = StRst;
        endcase

        // Wait counter is armed on entry so each memory state lasts exactly MEM_LAT cycles.
        if ((state_d == StFtch || state_d == StMrd) && state_d != state_q) begin
            wait_d = WaitW'(MEM_LAT - 1);
        end
        if (state_d == StFtch && state_q != StFtch && state_q != StRst) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StRst;
            wait_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
        end
    end

    assign bus.state   = state_q;
    assign bus.retired = retired_q;
endmodule

// File: tb/tb_cpu_ctrl_mc.sv
// Scoreboard bench: stimulus pushes per-cycle expected state/strobes/retired; monitor compares.
module tb_cpu_ctrl_mc;
    localparam int unsigned LAT = 3;

    localparam logic [4:0] RST = 5'd0, FTCH = 5'd1, LDIR = 5'd2, LDPC = 5'd3, RDRN = 5'd4,
        RDRM = 5'd5, WRRN = 5'd6, CALC = 5'd7, STAT = 5'd8, WMEM = 5'd9, WRRD = 5'd10,
        RDRD = 5'd11, EXBR = 5'd12, HALT = 5'd13, BXRD = 5'd14, BXPC = 5'd15, MRD = 5'd16;

    localparam logic [19:0] LOADIR = 20'd1 << 19, MSEL = 20'd1 << 18, MWRITE = 20'd1 << 17,
        NSEL10 = 20'd1 << 16, NSEL01 = 20'd1 << 15, VSEL10 = 20'd1 << 14, VSEL01 = 20'd1 << 13,
        VSEL11 = 20'd3 << 13, WRITE = 20'd1 << 12, ASEL = 20'd1 << 11, BSEL = 20'd1 << 10,
        LOADA = 20'd1 << 9, LOADB = 20'd1 << 8, LOADC = 20'd1 << 7, LOADS = 20'd1 << 6,
        TSEL = 20'd1 << 5, INCP = 20'd1 << 4, EXECB = 20'd1 << 3, HALTED = 20'd1 << 2,
        ILLEGAL = 20'd1 << 1;

    typedef struct packed {
        logic [4:0]  st;
        logic [19:0] outs;
        logic [15:0] ret;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_m, rst_1;
    logic        done = 1'b0;
    logic [3:0]  ret_m;
    logic [15:0] ret_1;
    exp_t        q_m[$];
    exp_t        q_1[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [19:0] outs_m, outs_1;

    cpu_ctrl_mc_if #(.CNT_W(4))  ifm ();
    cpu_ctrl_mc_if #(.CNT_W(16)) if1 ();

    cpu_ctrl_mc #(.MEM_LAT(LAT), .CNT_W(4)) u_dut (
        .clk   (clk),
        .reset (rst_m),
        .bus   (ifm)
    );

    cpu_ctrl_mc #(.MEM_LAT(1), .CNT_W(16)) u_dut1 (
        .clk   (clk),
        .reset (rst_1),
        .bus   (if1)
    );

    always #5 clk = ~clk;

    assign outs_m = {ifm.loadir, ifm.msel, ifm.mwrite, ifm.nsel, ifm.vsel, ifm.write, ifm.asel,
                     ifm.bsel, ifm.loada, ifm.loadb, ifm.loadc, ifm.loads, ifm.tsel, ifm.incp,
                     ifm.execb, ifm.halted, ifm.illegal, 1'b0};
    assign outs_1 = {if1.loadir, if1.msel, if1.mwrite, if1.nsel, if1.vsel, if1.write, if1.asel,
                     if1.bsel, if1.loada, if1.loadb, if1.loadc, if1.loads, if1.tsel, if1.incp,
                     if1.execb, if1.halted, if1.illegal, 1'b0};

    task automatic cyc(input logic [4:0] st, input logic [19:0] o);
        q_m.push_back('{st: st, outs: o, ret: {12'd0, ret_m}});
        @(posedge clk);
        #1;
    endtask

    task automatic cyc1(input logic [4:0] st, input logic [19:0] o);
        q_1.push_back('{st: st, outs: o, ret: ret_1});
        @(posedge clk);
        #1;
    endtask

    // Present an instruction and walk FTCH (LAT cycles) and LDIR.
    task automatic fetch(input logic [2:0] opc, input logic [1:0] o, input bit counts);
        ifm.opcode = opc;
        ifm.op     = o;
        ifm.run    = 1'b0;
        if (counts) ret_m = ret_m + 4'd1;
        repeat (LAT) cyc(FTCH, 20'd0);
        cyc(LDIR, LOADIR);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q_m.size() != 0) begin
            e = q_m.pop_front();
            check("state", 32'(ifm.state), 32'(e.st));
            check("strobes", 32'(outs_m), 32'(e.outs));
            check("retired", 32'(ifm.retired), 32'(e.ret));
        end
        if (q_1.size() != 0) begin
            e = q_1.pop_front();
            check("lat1_state", 32'(if1.state), 32'(e.st));
            check("lat1_strobes", 32'(outs_1), 32'(e.outs));
            check("lat1_retired", 32'(if1.retired), 32'(e.ret));
        end
        if (done) begin
            check("queue_drained", 32'(q_m.size() + q_1.size()), 32'd0);
            $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
            $finish;
        end
    end

    // MEM_LAT=1 instance repeatedly executing MOVi.
    initial begin
        rst_1      = 1'b1;
        if1.opcode = 3'b110;
        if1.op     = 2'b10;
        if1.run    = 1'b0;
        ret_1      = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_1 = 1'b0;
        cyc1(RST, 20'd0);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) ret_1 = ret_1 + 16'd1;
            cyc1(FTCH, 20'd0);
            cyc1(LDIR, LOADIR);
            cyc1(LDPC, INCP);
            cyc1(WRRN, WRITE | VSEL01);
        end
    end

    initial begin
        rst_m      = 1'b1;
        ifm.opcode = 3'b000;
        ifm.op     = 2'b00;
        ifm.run    = 1'b0;
        ret_m      = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_m = 1'b0;
        cyc(RST, 20'd0);
        // MOVi
        fetch(3'b110, 2'b10, 1'b0);
        cyc(LDPC, INCP); cyc(WRRN, WRITE | VSEL01);
        // LDR
        fetch(3'b011, 2'b00, 1'b1);
        cyc(LDPC, INCP); cyc(RDRN, LOADA); cyc(CALC, LOADC | BSEL);
        repeat (LAT) cyc(MRD, MSEL);
        cyc(WRRD, NSEL01 | WRITE | MSEL);
        // STR
        fetch(3'b100, 2'b00, 1'b1);
        cyc(LDPC, INCP); cyc(RDRN, LOADA); cyc(CALC, LOADC | BSEL);
        cyc(RDRD, NSEL01 | LOADB); cyc(WMEM, MSEL | MWRITE);
        // ADD, AND
        for (int k = 0; k < 2; k++) begin
            fetch(3'b101, (k == 0) ? 2'b00 : 2'b10, 1'b1);
            cyc(LDPC, INCP); cyc(RDRN, LOADA); cyc(RDRM, NSEL10 | LOADB);
            cyc(CALC, LOADC); cyc(WRRD, NSEL01 | WRITE | VSEL11);
        end
        // MOV
        fetch(3'b110, 2'b00, 1'b1);
        cyc(LDPC, INCP); cyc(RDRM, NSEL10 | LOADB); cyc(CALC, LOADC | ASEL);
        cyc(WRRD, NSEL01 | WRITE | VSEL11);
        // MVN
        fetch(3'b101, 2'b11, 1'b1);
        cyc(LDPC, INCP); cyc(RDRM, NSEL10 | LOADB); cyc(CALC, LOADC);
        cyc(WRRD, NSEL01 | WRITE | VSEL11);
        // CMP
        fetch(3'b101, 2'b01, 1'b1);
        cyc(LDPC, INCP); cyc(RDRN, LOADA); cyc(RDRM, NSEL10 | LOADB);
        cyc(CALC, 20'd0); cyc(STAT, LOADS);
        // BL, B, BX
        fetch(3'b010, 2'b11, 1'b1);
        cyc(LDPC, INCP); cyc(EXBR, EXECB | TSEL | WRITE | VSEL10);
        fetch(3'b001, 2'b10, 1'b1);
        cyc(LDPC, INCP); cyc(EXBR, EXECB | TSEL);
        fetch(3'b010, 2'b00, 1'b1);
        cyc(LDPC, INCP); cyc(BXRD, NSEL01 | LOADA); cyc(BXPC, EXECB);
        // Undefined encodings
        fetch(3'b000, 2'b01, 1'b1);
        cyc(LDPC, INCP | ILLEGAL);
        fetch(3'b010, 2'b01, 1'b1);
        cyc(LDPC, INCP | ILLEGAL);
        fetch(3'b110, 2'b11, 1'b1);
        cyc(LDPC, INCP | ILLEGAL);
        // NOP
        fetch(3'b000, 2'b00, 1'b1);
        cyc(LDPC, INCP);
        // HALT, then resume; the following fetch wraps the 4-bit counter to 0
        fetch(3'b111, 2'b00, 1'b1);
        cyc(LDPC, INCP);
        repeat (10) cyc(HALT, HALTED);
        ifm.run = 1'b1;
        cyc(HALT, HALTED);
        // LDR interrupted by reset mid-MRD
        fetch(3'b011, 2'b00, 1'b1);
        cyc(LDPC, INCP); cyc(RDRN, LOADA); cyc(CALC, LOADC | BSEL);
        cyc(MRD, MSEL);
        rst_m = 1'b1;
        cyc(MRD, MSEL);
        rst_m = 1'b0;
        ret_m = 4'd0;
        cyc(RST, 20'd0);
        // 17 NOPs: counter wraps to 1 on the following fetch
        for (int k = 0; k < 17; k++) begin
            fetch(3'b000, 2'b00, k > 0);
            cyc(LDPC, INCP);
        end
        fetch(3'b000, 2'b00, 1'b1);
        repeat (2) @(posedge clk);
        done = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion, expected finish before 200000");
        $fatal(1, "timeout");
    end
endmodule
